toa_tot_calc: RTL and testbench
===============================

TOA_TOT_CALC -- requirements
Module: toa_tot_calc

Interface
REQ-001 The block SHALL have the parameter FIFO_DEPTH, default 4, giving the output FIFO entries (power of 2, minimum 2).
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, with all logic on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous active-high reset.
REQ-005 The block SHALL have port hit_valid, input, 1 bit: one-cycle strobe marking a new hit on the fine/coarse inputs.
REQ-006 The block SHALL have port toa_fine, input, 6 bits: TOA fine code from the fine encoder (0..62; 6'h3F = encoder error).
REQ-007 The block SHALL have port toa_coarse, input, 3 bits: TOA coarse phase count.
REQ-008 The block SHALL have port tot_fine, input, 6 bits: TOT-stop fine code, with the same coding as toa_fine.
REQ-009 The block SHALL have port tot_coarse, input, 3 bits: TOT-stop coarse phase count.
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream accepts the output word.
REQ-011 The block SHALL have port out_valid, output, 1 bit: the FIFO head word is valid.
REQ-012 The block SHALL have port out_toa, output, 9 bits: TOA code.
REQ-013 The block SHALL have port out_tot, output, 9 bits: TOT code.
REQ-014 The block SHALL have port out_err, output, 1 bit: the hit carried an encoder error.
REQ-015 The block SHALL have port ovf, output, 1 bit: one-cycle pulse when a hit is dropped.
REQ-016 The block SHALL have port cnt_clr, input, 1 bit: synchronous clear of the statistics counters.
REQ-017 The block SHALL have port hit_cnt, output, 16 bits: count of accepted hits.
REQ-018 The block SHALL have port err_cnt, output, 16 bits: count of error hits.

Function
REQ-019 Stage 1 SHALL register the inputs and hit_valid on every rising clk edge.
REQ-020 Stage 2 SHALL register toa = toa_coarse*63 + toa_fine (range 0..503).
REQ-021 Stage 2 SHALL register tot = (tot_coarse*63 + tot_fine - toa) mod 504, with a negative difference wrapping by +504.
REQ-022 If toa_fine or tot_fine equals 6'h3F, stage 2 SHALL set err=1 and force toa=tot=9'h1FF.
REQ-023 The stage-2 word SHALL be written into the FIFO on the following edge: a hit sampled at edge k is written at edge k+2, and out_valid rises after edge k+2 if the FIFO was empty (3-cycle latency).
REQ-024 The FIFO SHALL be show-ahead: out_toa/out_tot/out_err always present the head entry while out_valid=1.
REQ-025 A transfer SHALL occur on an edge with out_valid=1 and out_ready=1.
REQ-026 While out_valid=1 and out_ready=0, the outputs SHALL remain stable.
REQ-027 If the FIFO is full with no simultaneous read, the incoming word SHALL be dropped, ovf pulsed for one cycle, and the FIFO contents left unchanged.
REQ-028 Simultaneous write and read while full SHALL both succeed, with the occupancy unchanged.
REQ-029 Simultaneous write and read while empty SHALL write the word, with out_valid rising on the next cycle (no bypass).
REQ-030 Back-to-back hit_valid on every cycle SHALL be accepted without loss while the FIFO is not full.
REQ-031 The FIFO read/write pointers SHALL be log2(FIFO_DEPTH)+1 bits wide, wrap modulo 2*FIFO_DEPTH, and full/empty SHALL be derived from the pointer MSB comparison.
REQ-032 out_valid, out_toa, out_tot and out_err SHALL be 0 while the FIFO is empty.

Reset
REQ-033 Reset SHALL clear the stage valids, FIFO pointers, ovf, out_valid, out_toa, out_tot, out_err, hit_cnt and err_cnt to 0 on the next edge.
REQ-034 Reset mid-operation SHALL discard in-flight and buffered hits, with no output word appearing afterwards from pre-reset hits.
REQ-035 Reset SHALL have priority over hit_valid, out_ready and cnt_clr.

Configuration
REQ-036 With macro TOA_TOT_STAT_CNT_EN defined, hit_cnt SHALL increment on each FIFO write, err_cnt SHALL increment on each FIFO write with err=1, both SHALL saturate at 16'hFFFF, and cnt_clr SHALL zero them (cnt_clr wins over an increment in the same cycle).
REQ-037 Without TOA_TOT_STAT_CNT_EN, no counter logic SHALL be synthesized, hit_cnt/err_cnt SHALL be tied to 0, and cnt_clr SHALL be ignored.

Verification
REQ-038 The bench SHALL cover: toa_fine=10, coarse=2, tot_fine=5, tot_coarse=4, out_ready=1 -> after 3 cycles out_valid=1, out_toa=136, out_tot=121, out_err=0.
REQ-039 The bench SHALL cover: toa coarse=7, fine=60 (toa=501), tot coarse=0, fine=3 -> out_tot=6 (wrap-around).
REQ-040 The bench SHALL cover: tot_fine=6'h3F -> out_err=1, out_toa=out_tot=9'h1FF, err_cnt+1 (macro on).
REQ-041 The bench SHALL cover: out_ready=0, 6 consecutive hits, FIFO_DEPTH=4 -> 4 stored, ovf pulses twice, the stored words drain in order once out_ready=1.
REQ-042 The bench SHALL cover: reset asserted with 2 hits in the pipeline and 3 in the FIFO -> out_valid=0 next cycle, with no stale words emitted afterwards.
REQ-043 The bench SHALL cover: hit_cnt at 16'hFFFE plus 3 hits -> 16'hFFFF; cnt_clr -> 0; without the macro, hit_cnt stays 0 throughout.

Source files
------------

// File: rtl/toa_tot_calc.sv
// toa_tot_calc: two-stage TOA/TOT code calculator feeding a show-ahead output FIFO
//   clk, reset         : single rising-edge clock, synchronous active-high reset
//   hit_valid          : one-cycle strobe qualifying toa_*/tot_* fine and coarse codes
//   out_valid/out_ready: FIFO head handshake; out_toa/out_tot/out_err carry the head word
//   ovf                : one-cycle pulse when a word is dropped on a full FIFO
//   cnt_clr, hit_cnt, err_cnt : statistics counters, present only with TOA_TOT_STAT_CNT_EN
module toa_tot_calc #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hit_valid,
  input  logic [5:0]  toa_fine,
  input  logic [2:0]  toa_coarse,
  input  logic [5:0]  tot_fine,
  input  logic [2:0]  tot_coarse,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [8:0]  out_toa,
  output logic [8:0]  out_tot,
  output logic        out_err,
  output logic        ovf,
  input  logic        cnt_clr,
  output logic [15:0] hit_cnt,
  output logic [15:0] err_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic        s1_v_q, s2_v_q, s2_err_q, ovf_q;
  logic [5:0]  s1_toa_f_q, s1_tot_f_q;
  logic [2:0]  s1_toa_c_q, s1_tot_c_q;
  logic [8:0]  s2_toa_q, s2_tot_q;
  logic [8:0]  s2_toa_d, s2_tot_d, toa_raw, tot_raw, tot_mod;
  logic [9:0]  diff;
  logic        s2_err_d;
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [18:0] mem_q [FIFO_DEPTH];
  logic [18:0] head;
  logic        empty, full, rd_en, wr_en, drop;
  always_comb begin
    s2_err_d = (s1_toa_f_q == 6'h3F) | (s1_tot_f_q == 6'h3F);
    toa_raw  = {6'd0, s1_toa_c_q} * 9'd63 + {3'd0, s1_toa_f_q};
    tot_raw  = {6'd0, s1_tot_c_q} * 9'd63 + {3'd0, s1_tot_f_q};
    // signed difference in 10 bits; a set MSB means the stop phase wrapped past 504
    diff     = {1'b0, tot_raw} - {1'b0, toa_raw};
    tot_mod  = diff[9] ? 9'(diff + 10'd504) : diff[8:0];
    s2_toa_d = s2_err_d ? 9'h1FF : toa_raw;
    s2_tot_d = s2_err_d ? 9'h1FF : tot_mod;
  end
  always_ff @(posedge clk) begin
    s1_toa_f_q <= toa_fine;
    s1_toa_c_q <= toa_coarse;
    s1_tot_f_q <= tot_fine;
    s1_tot_c_q <= tot_coarse;
    s2_toa_q   <= s2_toa_d;
    s2_tot_q   <= s2_tot_d;
    s2_err_q   <= s2_err_d;
  end
  // pointers carry one extra wrap bit: equal pointers mean empty, MSB-only difference means full
  always_comb begin
    empty = wr_ptr_q == rd_ptr_q;
    full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    rd_en = !empty && out_ready;
    wr_en = s2_v_q && (!full || rd_en);
    drop  = s2_v_q && full && !rd_en;
    head  = mem_q[rd_ptr_q[AW-1:0]];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v_q   <= 1'b0;
      s2_v_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      s1_v_q   <= hit_valid;
      s2_v_q   <= s1_v_q;
      wr_ptr_q <= wr_ptr_q + (AW+1)'(wr_en);
      rd_ptr_q <= rd_ptr_q + (AW+1)'(rd_en);
      ovf_q    <= drop;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en && !reset) mem_q[wr_ptr_q[AW-1:0]] <= {s2_err_q, s2_toa_q, s2_tot_q};
  end
  always_comb begin
    out_valid = !empty;
    out_err   = empty ? 1'b0 : head[18];
    out_toa   = empty ? 9'd0 : head[17:9];
    out_tot   = empty ? 9'd0 : head[8:0];
    ovf       = ovf_q;
  end
`ifdef TOA_TOT_STAT_CNT_EN
  logic [15:0] hit_cnt_q, err_cnt_q;
  always_ff @(posedge clk) begin
    if (reset || cnt_clr) begin
      hit_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      if (wr_en && hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
      if (wr_en && s2_err_q && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end
  assign hit_cnt = hit_cnt_q;
  assign err_cnt = err_cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign hit_cnt = '0;
  assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_toa_tot_calc.sv
// tb_toa_tot_calc: randomized and directed checks of toa_tot_calc against a queue-based reference
module tb_toa_tot_calc;
  localparam int D = 4;
  logic clk = 1'b0;
  logic reset, hit_valid, out_ready, cnt_clr;
  logic [5:0] toa_fine, tot_fine;
  logic [2:0] toa_coarse, tot_coarse;
  logic out_valid, out_err, ovf;
  logic [8:0] out_toa, out_tot;
  logic [15:0] hit_cnt, err_cnt;
  int n_vec = 0, n_err = 0, ovf_seen = 0, hc = 0, ec = 0;
  logic [18:0] q[$];
  logic p1v = 0, p2v = 0, ovf_e = 0;
  logic [18:0] p1w = '0, p2w = '0;
  toa_tot_calc #(.FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .hit_valid(hit_valid),
    .toa_fine(toa_fine), .toa_coarse(toa_coarse), .tot_fine(tot_fine), .tot_coarse(tot_coarse),
    .out_ready(out_ready), .out_valid(out_valid), .out_toa(out_toa), .out_tot(out_tot),
    .out_err(out_err), .ovf(ovf), .cnt_clr(cnt_clr), .hit_cnt(hit_cnt), .err_cnt(err_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  function automatic logic [18:0] ref_word(input int tf, input int tc, input int sf, input int sc);
    int a, b;
    if (tf == 63 || sf == 63) return {1'b1, 9'h1FF, 9'h1FF};
    a = tc * 63 + tf;
    b = sc * 63 + sf;
    return {1'b0, 9'(a), 9'((b - a + 504) % 504)};
  endfunction
  task automatic cycle(input logic hv, input int tf, input int tc, input int sf, input int sc,
                       input logic rdy, input logic clr, input logic rst);
    logic rd, ok;
    hit_valid = hv; toa_fine = 6'(tf); toa_coarse = 3'(tc); tot_fine = 6'(sf); tot_coarse = 3'(sc);
    out_ready = rdy; cnt_clr = clr; reset = rst;
    @(posedge clk);
    if (rst) begin
      q.delete(); p1v = 0; p2v = 0; ovf_e = 0; hc = 0; ec = 0;
    end else begin
      rd = q.size() > 0 && rdy;
      ok = p2v && (q.size() < D || rd);
      ovf_e = p2v && !ok;
      if (rd) void'(q.pop_front());
      if (ok) q.push_back(p2w);
`ifdef TOA_TOT_STAT_CNT_EN
      if (clr) begin
        hc = 0; ec = 0;
      end else if (ok) begin
        if (hc < 65535) hc++;
        if (p2w[18] && ec < 65535) ec++;
      end
`endif
      p2v = p1v; p2w = p1w;
      p1v = hv; p1w = ref_word(tf, tc, sf, sc);
    end
    @(negedge clk);
    check("out_valid", 32'(out_valid), 32'(q.size() > 0));
    check("out_word", 32'({out_err, out_toa, out_tot}), 32'(q.size() > 0 ? q[0] : 19'd0));
    check("ovf", 32'(ovf), 32'(ovf_e));
    check("hit_cnt", 32'(hit_cnt), hc);
    check("err_cnt", 32'(err_cnt), ec);
    if (ovf) ovf_seen++;
  endtask
  task automatic idle(input logic rdy);
    cycle(1'b0, 0, 0, 0, 0, rdy, 1'b0, 1'b0);
  endtask
  task automatic hit(input int tf, input int tc, input int sf, input int sc, input logic rdy);
    cycle(1'b1, tf, tc, sf, sc, rdy, 1'b0, 1'b0);
  endtask
  initial begin
    int nread;
    logic err_case;
    cycle(0, 0, 0, 0, 0, 1, 0, 1);
    cycle(0, 0, 0, 0, 0, 1, 0, 1);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_hit_cnt", 32'(hit_cnt), 0);
    hit(10, 2, 5, 4, 1);
    idle(1);
    check("lat_not_yet", 32'(out_valid), 0);
    idle(1);
    check("lat_valid", 32'(out_valid), 1);
    check("basic_toa", 32'(out_toa), 136);
    check("basic_tot", 32'(out_tot), 121);
    check("basic_err", 32'(out_err), 0);
    idle(1);
    hit(60, 7, 3, 0, 1);
    idle(1);
    idle(1);
    check("wrap_toa", 32'(out_toa), 501);
    check("wrap_tot", 32'(out_tot), 6);
    idle(1);
    hit(12, 1, 63, 2, 1);
    idle(1);
    idle(1);
    check("err_flag", 32'(out_err), 1);
    check("err_toa", 32'(out_toa), 32'h1FF);
    check("err_tot", 32'(out_tot), 32'h1FF);
`ifdef TOA_TOT_STAT_CNT_EN
    check("err_cnt_inc", 32'(err_cnt), 1);
    check("hit_cnt_3", 32'(hit_cnt), 3);
`else
    check("err_cnt_off", 32'(err_cnt), 0);
`endif
    idle(1);
    idle(1);
    ovf_seen = 0;
    for (int i = 0; i < 6; i++) hit(i * 3, i, 40 - i, 7 - i, 0);
    for (int i = 0; i < 3; i++) idle(0);
    check("ovf_pulses", ovf_seen, 2);
    check("full_valid", 32'(out_valid), 1);
    nread = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) nread++;
      idle(1);
    end
    check("drain_count", nread, 4);
    for (int i = 0; i < 5; i++) hit(20 + i, i, 10, 3, 0);
    cycle(0, 0, 0, 0, 0, 1, 0, 1);
    check("rst_mid_valid", 32'(out_valid), 0);
    for (int i = 0; i < 6; i++) begin
      idle(1);
      check("no_stale", 32'(out_valid), 0);
    end
    for (int i = 0; i < 2000; i++) begin
      err_case = $urandom_range(0, 11) == 0;
      cycle($urandom_range(0, 1) == 1,
            err_case && $urandom_range(0, 1) == 1 ? 63 : $urandom_range(0, 62), $urandom_range(0, 7),
            err_case ? 63 : $urandom_range(0, 62), $urandom_range(0, 7),
            ((i / 250) % 2 == 0) ? $urandom_range(0, 3) != 0 : $urandom_range(0, 3) == 0,
            $urandom_range(0, 99) == 0, $urandom_range(0, 199) == 0);
    end
    cycle(0, 0, 0, 0, 0, 1, 0, 1);
`ifdef TOA_TOT_STAT_CNT_EN
    for (int i = 0; i < 65534; i++) hit(i % 63, i % 8, (i + 7) % 63, (i + 3) % 8, 1);
    idle(1);
    idle(1);
    check("cnt_fffe", 32'(hit_cnt), 32'hFFFE);
`endif
    for (int i = 0; i < 3; i++) hit(5, 1, 9, 2, 1);
    idle(1);
    idle(1);
`ifdef TOA_TOT_STAT_CNT_EN
    check("cnt_sat", 32'(hit_cnt), 32'hFFFF);
`else
    check("cnt_off", 32'(hit_cnt), 0);
`endif
    cycle(0, 0, 0, 0, 0, 1, 1, 0);
    check("cnt_clr", 32'(hit_cnt), 0);
    idle(1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
